zorro_write_queue: RTL

Parametrised write-posting queue between the Zorro II bus slave logic and the SDRAM controller command port. It accepts host writes (byte address, data, byte lanes) in one cycle, buffers up to `DEPTH` entries and drains them one at a time as 32-bit masked SDRAM write commands. Unlike the earlier inline queue it has real full/overflow protection, level reporting for the I/O-space status register, a drain-inhibit input for the line-fetch arbiter, and selectable 16/32-bit host width.

---
 rtl/zorro_write_queue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/zorro_write_queue.sv
// Write-posting queue from the Zorro II slave to the SDRAM command port.
// Optional write coalescing into the newest entry: define WRITEQ_COALESCE_EN.
module zorro_write_queue #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  drain_inhibit,
    input  logic                  cmd_ready,
    output logic                  cmd_enable,
    output logic                  cmd_wr,
    output logic [ADDR_W-1:0]     cmd_address,
    output logic [31:0]           cmd_data_in,
    output logic [3:0]            cmd_byte_enable,
    output logic [LVL_W-1:0]      level,
    output logic [LVL_W-1:0]      free,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    input  logic                  overflow_clr
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

    logic [ADDR_W-1:0] r_q_addr [DEPTH];
    logic [31:0]       r_q_data [DEPTH];
    logic [3:0]        r_q_be   [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [LVL_W-1:0]  r_level;
    logic [LVL_W-1:0]  r_free;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    state_t            r_state;
    logic              r_cmd_enable;
    logic              r_cmd_wr;
    logic [ADDR_W-1:0] r_cmd_address;
    logic [31:0]       r_cmd_data;
    logic [3:0]        r_cmd_be;

    logic [ADDR_W-1:0] w_in_addr;
    logic [31:0]       w_in_data;
    logic [3:0]        w_in_be;
    logic              w_hit;
    logic              w_ready;
    logic              w_push;
    logic              w_start;
    logic              w_pop;
    logic [LVL_W-1:0]  w_level_nxt;

    assign w_in_addr = {wr_addr[ADDR_W-1:2], 2'b00};

    generate
        if (DATA_W == 16) begin : g_host16
            assign w_in_data = {wr_data, wr_data};
            assign w_in_be   = wr_addr[1] ? {wr_be, 2'b00} : {2'b00, wr_be};
        end else begin : g_host32
            assign w_in_data = wr_data;
            assign w_in_be   = wr_be;
        end
    endgenerate

    assign w_start = (r_state == ST_IDLE) && !r_empty && cmd_ready && !drain_inhibit;
    assign w_pop   = (r_state == ST_ISSUE) && cmd_ready;

`ifdef WRITEQ_COALESCE_EN
    logic [PTR_W-1:0] w_newest;
    logic [31:0]      w_merge_data;

    assign w_newest = r_tail - PTR_W'(1);
    // A lone entry that is being (or about to be) issued must not change under the command.
    assign w_hit = !r_empty && (r_q_addr[w_newest] == w_in_addr) &&
                   !((r_level == LVL_W'(1)) && ((r_state == ST_ISSUE) || w_start));

    always_comb begin
        w_merge_data = r_q_data[w_newest];
        for (int unsigned i = 0; i < 4; i++) begin
            if (w_in_be[i]) w_merge_data[i*8 +: 8] = w_in_data[i*8 +: 8];
        end
    end
`else
    assign w_hit = 1'b0;
`endif

    assign w_ready     = !r_full || w_hit;
    assign w_push      = wr_valid && w_ready && !w_hit;
    assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_tail] <= w_in_addr;
            r_q_data[r_tail] <= w_in_data;
            r_q_be[r_tail]   <= w_in_be;
        end
`ifdef WRITEQ_COALESCE_EN
        else if (wr_valid && w_hit) begin
            r_q_data[w_newest] <= w_merge_data;
            r_q_be[w_newest]   <= r_q_be[w_newest] | w_in_be;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_level    <= '0;
            r_free     <= LVL_W'(DEPTH);
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_tail <= r_tail + PTR_W'(1);
            if (w_pop)  r_head <= r_head + PTR_W'(1);
            r_level <= w_level_nxt;
            r_free  <= LVL_W'(DEPTH) - w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
            if (wr_valid && !w_ready) r_overflow <= 1'b1;
            else if (overflow_clr)    r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cmd_enable  <= 1'b0;
            r_cmd_wr      <= 1'b0;
            r_cmd_address <= '0;
            r_cmd_data    <= '0;
            r_cmd_be      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_cmd_enable  <= 1'b1;
                        r_cmd_wr      <= 1'b1;
                        r_cmd_address <= r_q_addr[r_head];
                        r_cmd_data    <= r_q_data[r_head];
                        r_cmd_be      <= r_q_be[r_head];
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        r_cmd_enable <= 1'b0;
                        r_cmd_wr     <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_ready        = w_ready;
    assign cmd_enable      = r_cmd_enable;
    assign cmd_wr          = r_cmd_wr;
    assign cmd_address     = r_cmd_address;
    assign cmd_data_in     = r_cmd_data;
    assign cmd_byte_enable = r_cmd_be;
    assign level           = r_level;
    assign free            = r_free;
    assign full            = r_full;
    assign empty           = r_empty;
    assign overflow        = r_overflow;

endmodule
